// File: rtl/velocity_sample_scheduler.sv
`timescale 1ns/1ps
// velocity_sample_scheduler
//
// Measures encoder-tick periods for the BLDC velocity loop. A prescaler
// derives a microsecond strobe from clk, an elapsed counter measures the
// time since the last tick, and each tick in RUN produces a period sample
// together with a sliding-window average. Stall (no tick for STALL_US) and
// direction reversal are detected, and samples are handed to the PID stage
// over a valid/ready handshake.
//
// Ports
//   clk            in   clock
//   reset          in   asynchronous, active-high reset
//   enable         in   measurement enable; low returns everything to IDLE
//   tick           in   single-cycle pulse per encoder state change
//   dir            in   encoder direction, sampled with tick (1 = forward)
//   sample_ready   in   consumer accepts the current sample
//   sample_valid   out  sample pending
//   period_us      out  latest single-tick period in microseconds
//   avg_period_us  out  window average period
//   direction      out  dir captured at the latest sampled tick
//   stalled        out  stall condition active
//   overrun        out  sticky: a pending sample was overwritten
//
// Handshake: a sample is transferred on every clock edge where
// sample_valid && sample_ready. The outputs hold while sample_valid is high
// and sample_ready is low. A new sample arriving while the current one is
// pending and not being accepted replaces it (latest wins) and sets overrun;
// a new sample arriving on the accepting edge simply becomes the next one.
module velocity_sample_scheduler #(
    parameter int          CLKS_PER_US = 50,
    parameter int          STALL_US    = 100000,
    parameter int          AVG_LOG2    = 2,
    parameter logic [31:0] MAX_PERIOD  = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        tick,
    input  logic        dir,
    input  logic        sample_ready,
    output logic        sample_valid,
    output logic [31:0] period_us,
    output logic [31:0] avg_period_us,
    output logic        direction,
    output logic        stalled,
    output logic        overrun
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = 32 + AVG_LOG2;
    localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int PRE_W = $clog2(CLKS_PER_US);
    localparam logic [SUM_W-1:0] SUM_RESET = SUM_W'(MAX_PERIOD) << AVG_LOG2;

    typedef enum logic [1:0] {IDLE, FIRST, RUN, STALL} state_t;

    state_t state, state_next;

    logic [PRE_W-1:0] presc;
    logic             us_strobe;
    logic [31:0]      elapsed;

    // Tick capture stage: the tick is registered together with the elapsed
    // time at that edge, and the FSM acts on it one edge later.
    logic             tick_q;
    logic             dir_q;
    logic [31:0]      period_q;

    logic [31:0]      win [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] sum_upd;

    logic stall_hit;
    logic emit_sample;
    logic emit_stall;
    logic latch_dir;
    logic new_sample;

    assign us_strobe  = (presc == PRE_W'(CLKS_PER_US - 1));
    // A tick on the threshold edge wins over the stall.
    assign stall_hit  = (elapsed == 32'(STALL_US)) && !tick;
    assign sum_upd    = sum - SUM_W'(win[ptr]) + SUM_W'(period_q);
    assign ptr_next   = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    assign new_sample = emit_sample || emit_stall;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        emit_sample = 1'b0;
        emit_stall  = 1'b0;
        latch_dir   = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = FIRST;
                FIRST: begin
                    if (tick_q) begin
                        state_next = RUN;
                        latch_dir  = 1'b1;
                    end else if (stall_hit) begin
                        state_next = STALL;
                        emit_stall = 1'b1;
                    end
                end
                RUN: begin
                    if (tick_q) begin
                        emit_sample = 1'b1;
                    end else if (stall_hit) begin
                        state_next = STALL;
                        emit_stall = 1'b1;
                    end
                end
                STALL: begin
                    // The interval ending here spans the stall; it only
                    // re-arms the measurement.
                    if (tick_q) begin
                        state_next = RUN;
                        latch_dir  = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // --------------------------------------------- timebase and tick capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc    <= '0;
            elapsed  <= '0;
            tick_q   <= 1'b0;
            dir_q    <= 1'b0;
            period_q <= '0;
        end else if (!enable) begin
            presc    <= '0;
            elapsed  <= '0;
            tick_q   <= 1'b0;
            dir_q    <= 1'b0;
            period_q <= '0;
        end else begin
            presc <= us_strobe ? '0 : presc + 1'b1;
            if (tick) begin
                elapsed <= '0;
            end else if (us_strobe && (elapsed != '1)) begin
                elapsed <= elapsed + 32'd1;
            end
            tick_q <= tick && (state != IDLE);
            if (tick) begin
                dir_q    <= dir;
                period_q <= elapsed;
            end
        end
    end

    // ------------------------------------------- window, outputs, handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_us     <= MAX_PERIOD;
            avg_period_us <= MAX_PERIOD;
            direction     <= 1'b0;
            stalled       <= 1'b0;
            sample_valid  <= 1'b0;
            overrun       <= 1'b0;
            sum           <= SUM_RESET;
            ptr           <= '0;
            for (int i = 0; i < DEPTH; i++) win[i] <= MAX_PERIOD;
        end else if (!enable) begin
            period_us     <= MAX_PERIOD;
            avg_period_us <= MAX_PERIOD;
            direction     <= 1'b0;
            stalled       <= 1'b0;
            sample_valid  <= 1'b0;
            overrun       <= 1'b0;
            sum           <= SUM_RESET;
            ptr           <= '0;
            for (int i = 0; i < DEPTH; i++) win[i] <= MAX_PERIOD;
        end else begin
            if (emit_stall) begin
                period_us     <= MAX_PERIOD;
                avg_period_us <= MAX_PERIOD;
                stalled       <= 1'b1;
                sum           <= SUM_RESET;
                ptr           <= '0;
                for (int i = 0; i < DEPTH; i++) win[i] <= MAX_PERIOD;
            end
            if (latch_dir) begin
                direction <= dir_q;
                stalled   <= 1'b0;
            end
            if (emit_sample) begin
                period_us <= period_q;
                direction <= dir_q;
                if (dir_q != direction) begin
                    // Reversal: periods from the old direction say nothing
                    // about the new one, so the window restarts full of the
                    // new period.
                    for (int i = 0; i < DEPTH; i++) win[i] <= period_q;
                    sum           <= SUM_W'(period_q) << AVG_LOG2;
                    avg_period_us <= period_q;
                    ptr           <= '0;
                end else begin
                    win[ptr]      <= period_q;
                    sum           <= sum_upd;
                    avg_period_us <= 32'(sum_upd >> AVG_LOG2);
                    ptr           <= ptr_next;
                end
            end
            if (new_sample) begin
                sample_valid <= 1'b1;
                if (sample_valid && !sample_ready) begin
                    overrun <= 1'b1;
                end
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_velocity_sample_scheduler.sv
`timescale 1ns/1ps
module tb_velocity_sample_scheduler;

    localparam int          C     = 4;
    localparam int          STALL = 1000;
    localparam int          L     = 2;
    localparam logic [31:0] MAXP  = 32'hFFFFFFFF;

    // ------------------------------------------------ clock / reset / DUT
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        tick;
    logic        dir;
    logic        sample_ready;
    logic        sample_valid;
    logic [31:0] period_us;
    logic [31:0] avg_period_us;
    logic        direction;
    logic        stalled;
    logic        overrun;

    always #5 clk = ~clk;

    velocity_sample_scheduler #(
        .CLKS_PER_US(C),
        .STALL_US   (STALL),
        .AVG_LOG2   (L),
        .MAX_PERIOD (MAXP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .tick         (tick),
        .dir          (dir),
        .sample_ready (sample_ready),
        .sample_valid (sample_valid),
        .period_us    (period_us),
        .avg_period_us(avg_period_us),
        .direction    (direction),
        .stalled      (stalled),
        .overrun      (overrun)
    );

    // ------------------------------------------------ scoreboard state
    typedef struct packed {
        logic [31:0] period;
        logic [31:0] avg;
        logic        dir;
        logic        stalled;
        logic        ovr;
    } smp_t;

    smp_t exp_q[$];
    smp_t mon_s;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: time is the index of enabled clock edges since the
    // last reset/disable; a microsecond boundary lies on every C-th edge.
    int                 e;
    int                 last_clr;
    bit                 m_active, m_have_ref, m_stalled, m_dir;
    bit                 m_valid, m_vis, m_overrun;
    bit                 pend_tick, pend_dir;
    logic [31:0]        pend_period;
    longint unsigned    win_q[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Microsecond boundaries strictly between the last clearing tick and
    // edge idx, i.e. the elapsed count seen at edge idx.
    function automatic int elapsed_at(int idx);
        return (idx - 1) / C - last_clr / C;
    endfunction

    function automatic void fill(longint unsigned v);
        win_q.delete();
        for (int i = 0; i < (1 << L); i++) win_q.push_back(v);
    endfunction

    function automatic logic [31:0] win_avg();
        longint unsigned s = 0;
        foreach (win_q[i]) s += win_q[i];
        return 32'(s >> L);
    endfunction

    function automatic void model_clear();
        e = 0; last_clr = 0;
        m_active = 0; m_have_ref = 0; m_stalled = 0; m_dir = 0;
        m_valid = 0; m_overrun = 0; pend_tick = 0; pend_dir = 0; pend_period = '0;
        fill(MAXP);
        exp_q.delete();
    endfunction

    function automatic bit rdy_of(int m);
        if (m == 0) return 1'b0;
        if (m == 1) return 1'b1;
        return ($urandom_range(0, 99) < 70);
    endfunction

    // ------------------------------------------------ driver tasks
    // Called just after a rising edge; sets inputs for the next edge and
    // advances the model across that edge.
    task automatic cycle(input bit tk, input bit dv, input bit rdy);
        smp_t s;
        smp_t t;
        bit   emit = 0;
        bit   accept;
        bit   was_active;
        int   el;
        enable = 1'b1; tick = tk; dir = dv; sample_ready = rdy;
        m_vis = m_valid;
        e++;
        el = elapsed_at(e);
        accept = m_valid && rdy;
        was_active = m_active;
        s = '0;
        if (!m_active) begin
            m_active = 1;
        end else if (pend_tick) begin
            if (!m_have_ref || m_stalled) begin
                m_have_ref = 1; m_stalled = 0; m_dir = pend_dir;
                if (m_valid && !accept) begin
                    t = exp_q.pop_back();
                    t.dir = m_dir; t.stalled = 1'b0;
                    exp_q.push_back(t);
                end
            end else begin
                if (pend_dir != m_dir) fill(pend_period);
                else begin
                    void'(win_q.pop_front());
                    win_q.push_back(pend_period);
                end
                m_dir = pend_dir;
                s.period = pend_period; s.avg = win_avg(); s.dir = m_dir; s.stalled = 1'b0;
                emit = 1;
            end
        end else if (!m_stalled && !tk && el == STALL) begin
            m_stalled = 1;
            fill(MAXP);
            s.period = MAXP; s.avg = MAXP; s.dir = m_dir; s.stalled = 1'b1;
            emit = 1;
        end
        if (tk) begin
            pend_tick = was_active; pend_period = 32'(el); pend_dir = dv; last_clr = e;
        end else begin
            pend_tick = 0;
        end
        if (emit) begin
            if (m_valid && !rdy) begin
                m_overrun = 1; s.ovr = 1'b1;
                void'(exp_q.pop_back());
                exp_q.push_back(s);
            end else begin
                s.ovr = m_overrun;
                exp_q.push_back(s);
            end
            m_valid = 1;
        end else if (accept) begin
            m_valid = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic gap(input int n, input int rmode);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, rdy_of(rmode));
    endtask

    task automatic tick1(input bit d, input int rmode);
        cycle(1'b1, d, rdy_of(rmode));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_period"},  period_us, MAXP);
        chk({tag, "_avg"},     avg_period_us, MAXP);
        chk({tag, "_dir"},     32'(direction), 32'd0);
        chk({tag, "_stalled"}, 32'(stalled), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
        chk({tag, "_valid"},   32'(sample_valid), 32'd0);
    endtask

    task automatic do_disable();
        enable = 1'b0; tick = 1'b0; sample_ready = 1'b0;
        m_vis = m_valid;
        model_clear();
        @(posedge clk); #1;
        check_idle("disable");
    endtask

    task automatic do_reset();
        reset = 1'b1; tick = 1'b0; sample_ready = 1'b0;
        #1;
        check_idle("reset_mid");
        model_clear();
        m_vis = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ------------------------------------------------ monitor
    always @(negedge clk) begin
        if (!reset) begin
            chk("valid", 32'(sample_valid), 32'(m_vis));
            if (sample_valid && sample_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_sample: got period %h, expected no sample at %0t",
                             period_us, $time);
                end else begin
                    mon_s = exp_q.pop_front();
                    chk("sample_period",  period_us, mon_s.period);
                    chk("sample_avg",     avg_period_us, mon_s.avg);
                    chk("sample_dir",     32'(direction), 32'(mon_s.dir));
                    chk("sample_stalled", 32'(stalled), 32'(mon_s.stalled));
                    chk("sample_overrun", 32'(overrun), 32'(mon_s.ovr));
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached before end of stimulus");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------ stimulus
    initial begin
        bit cur_dir;
        int g;
        reset = 1'b1; enable = 1'b0; tick = 1'b0; dir = 1'b0; sample_ready = 1'b0;
        model_clear();
        m_vis = 0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        reset = 1'b0;

        // First tick arms, second tick 400 cycles later reports 100 us.
        gap(5, 1);
        tick1(1'b1, 1);
        gap(399, 1);
        tick1(1'b1, 1);
        gap(3, 1);
        chk("tp_first_period", period_us, 32'd100);
        chk("tp_first_avg", avg_period_us, 32'hC0000018);

        for (int i = 0; i < 4; i++) begin
            gap(199, 1);
            tick1(1'b1, 1);
        end
        gap(3, 1);
        chk("tp_steady_period", period_us, 32'd50);
        chk("tp_steady_avg", avg_period_us, 32'd50);

        // Stall and recovery.
        gap(4010, 1);
        chk("tp_stall_flag", 32'(stalled), 32'd1);
        chk("tp_stall_period", period_us, MAXP);
        tick1(1'b1, 1);
        gap(3, 1);
        chk("tp_unstall_flag", 32'(stalled), 32'd0);

        // Reversal after a forward run.
        for (int i = 0; i < 5; i++) begin
            gap(199, 1);
            tick1(1'b1, 1);
        end
        gap(119, 1);
        tick1(1'b0, 1);
        gap(3, 1);
        chk("tp_rev_dir", 32'(direction), 32'd0);
        chk("tp_rev_period", period_us, 32'd30);
        chk("tp_rev_avg", avg_period_us, 32'd30);

        // Tick landing exactly on the stall threshold.
        while (elapsed_at(e + 1) < STALL) cycle(1'b0, 1'b0, 1'b1);
        tick1(1'b0, 1);
        gap(3, 1);
        chk("tie_stalled", 32'(stalled), 32'd0);
        chk("tie_period", period_us, 32'd1000);

        // Two samples with ready low: latest wins, overrun set.
        gap(199, 0);
        tick1(1'b0, 0);
        gap(199, 0);
        tick1(1'b0, 0);
        gap(3, 0);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_valid", 32'(sample_valid), 32'd1);
        cycle(1'b0, 1'b0, 1'b1);
        chk("ovr_valid_drop", 32'(sample_valid), 32'd0);
        gap(5, 0);

        // Randomized traffic.
        cur_dir = 1'b0;
        for (int i = 0; i < 150; i++) begin
            g = $urandom_range(0, 250);
            if ($urandom_range(0, 29) == 0) g = 4100;
            gap(g, $urandom_range(0, 3) == 0 ? 0 : 2);
            if ($urandom_range(0, 4) == 0) cur_dir = ~cur_dir;
            tick1(cur_dir, 2);
            if ($urandom_range(0, 39) == 0) begin
                gap(2, 0);
                do_disable();
                gap(3, 1);
            end
        end

        // Disable with a pending sample, then the FIRST rule again.
        gap(20, 1);
        gap(199, 1);
        tick1(1'b1, 0);
        gap(3, 0);
        do_disable();
        gap(5, 1);
        tick1(1'b1, 1);
        gap(99, 1);
        tick1(1'b1, 1);
        gap(3, 1);
        chk("reen_period", period_us, 32'd25);

        // Asynchronous reset with a pending sample.
        gap(99, 0);
        tick1(1'b1, 0);
        gap(3, 0);
        do_reset();
        gap(5, 1);
        tick1(1'b0, 1);
        gap(199, 1);
        tick1(1'b0, 1);
        gap(10, 1);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_samples: got %0d undelivered, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
